mlp_train_sequencer: RTL and testbench

//  Epoch/sample sequencer for the MLP training datapath.
//  - Walks a sample store index by index and pulses sample load.
//  - Waits a programmable settle time for the forward pass.
//  - Pulses MLP training for exactly one cycle per sample.
//  - Counts epochs, halves the learning rate on a fixed epoch interval, reports done/abort.

---
 rtl/mlp_train_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_train_sequencer.sv
// rtl/mlp_train_sequencer.sv - epoch/sample sequencer driving MLP load/settle/train pulses
module mlp_train_sequencer #(
    parameter int MAX_SAMPLES   = 256,
    parameter int MAX_EPOCHS    = 1024,
    parameter int SETTLE_W      = 8,
    parameter int DECAY_EPOCHS  = 0,
    localparam int IDX_W        = $clog2(MAX_SAMPLES),
    localparam int EP_W         = $clog2(MAX_EPOCHS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,           // synchronous, active-low
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [IDX_W:0]      num_samples_i,
    input  logic [EP_W-1:0]     num_epochs_i,
    input  logic [SETTLE_W-1:0] settle_cycles_i,
    input  real                 lr_init_i,
    output logic [IDX_W-1:0]    sample_idx_o,
    output logic                sample_load_o,
    output logic                training_o,
    output real                 learning_rate_o,
    output logic [EP_W-1:0]     epoch_count_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        TRAIN,
        NEXT,
        FINISH
    } state_t;

    // A zero interval disables decay; the divisor is kept non-zero so the
    // modulo below is always well defined even when it is never used.
    localparam int              DECAY_DIV = (DECAY_EPOCHS == 0) ? 1 : DECAY_EPOCHS;
    localparam logic [EP_W-1:0] DECAY_V   = EP_W'(DECAY_DIV);
    localparam logic            DECAY_ON  = (DECAY_EPOCHS != 0);

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [EP_W-1:0]     ep_q, ep_d;
    logic [IDX_W:0]      n_q, n_d;
    logic [EP_W-1:0]     e_q, e_d;
    logic [SETTLE_W-1:0] s_q, s_d;
    real                 lr_q, lr_d;

    logic                sample_load_q, training_q, busy_q, done_q, aborted_q;
    logic                abort_hit;
    logic [EP_W-1:0]     ep_inc;

    // abort is meaningful only while a run is active and not already finishing
    assign abort_hit = abort_i && (state_q != IDLE) && (state_q != FINISH);
    assign ep_inc    = ep_q + EP_W'(1);

    // Next-state and datapath update; abort freezes the datapath and returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ep_d    = ep_q;
        n_d     = n_q;
        e_d     = e_q;
        s_d     = s_q;
        lr_d    = lr_q;
        if (abort_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_d     = num_samples_i;
                        e_d     = num_epochs_i;
                        s_d     = settle_cycles_i;
                        lr_d    = lr_init_i;
                        idx_d   = '0;
                        ep_d    = '0;
                        state_d = ((num_samples_i == '0) || (num_epochs_i == '0)) ? FINISH : LOAD;
                    end
                end
                LOAD: begin
                    cnt_d   = s_q;
                    state_d = (s_q == '0) ? TRAIN : SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_W'(1)) begin
                        state_d = TRAIN;
                    end else begin
                        cnt_d = cnt_q - SETTLE_W'(1);
                    end
                end
                TRAIN: begin
                    state_d = NEXT;
                end
                NEXT: begin
                    if ({1'b0, idx_q} < (n_q - (IDX_W + 1)'(1))) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end else begin
                        idx_d = '0;
                        ep_d  = ep_inc;
                        if (DECAY_ON && ((ep_inc % DECAY_V) == '0)) begin
                            lr_d = lr_q * 0.5;
                        end
                        state_d = (ep_inc == e_q) ? FINISH : LOAD;
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, configuration and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ep_q    <= '0;
            n_q     <= '0;
            e_q     <= '0;
            s_q     <= '0;
            lr_q    <= 0.0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ep_q    <= ep_d;
            n_q     <= n_d;
            e_q     <= e_d;
            s_q     <= s_d;
            lr_q    <= lr_d;
        end
    end

    // Registered Moore strobes: each reflects the state just occupied, so an
    // abort taken in TRAIN still lets that cycle's training pulse out
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sample_load_q <= 1'b0;
            training_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            sample_load_q <= (state_q == LOAD);
            training_q    <= (state_q == TRAIN);
            busy_q        <= (state_q != IDLE);
            done_q        <= (state_q == FINISH);
            aborted_q     <= abort_hit;
        end
    end

    assign sample_idx_o    = idx_q;
    assign sample_load_o   = sample_load_q;
    assign training_o      = training_q;
    assign learning_rate_o = lr_q;
    assign epoch_count_o   = ep_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign aborted_o       = aborted_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// tb/tb_mlp_train_sequencer.sv - directed self-checking bench for mlp_train_sequencer
module tb_mlp_train_sequencer;

    localparam int IDX_W    = 8;
    localparam int EP_W     = 11;
    localparam int SETTLE_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [IDX_W:0]      num_samples = '0;
    logic [EP_W-1:0]     num_epochs = '0;
    logic [SETTLE_W-1:0] settle_cycles = '0;
    real                 lr_init = 0.0;

    logic [IDX_W-1:0]    idx_a, idx_b;
    logic                load_a, load_b, train_a, train_b;
    real                 lr_a, lr_b;
    logic [EP_W-1:0]     ep_a, ep_b;
    logic                busy_a, busy_b, done_a, done_b, abt_a, abt_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int at = 0;
    int busy_cnt = 0;
    int train_cyc[$];
    int train_idx[$];
    int load_cyc[$];
    int done_cyc[$];
    int abt_cyc[$];

    always #5 clk = ~clk;

    mlp_train_sequencer u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .num_samples_i(num_samples), .num_epochs_i(num_epochs),
        .settle_cycles_i(settle_cycles), .lr_init_i(lr_init),
        .sample_idx_o(idx_a), .sample_load_o(load_a), .training_o(train_a),
        .learning_rate_o(lr_a), .epoch_count_o(ep_a), .busy_o(busy_a),
        .done_o(done_a), .aborted_o(abt_a)
    );

    mlp_train_sequencer #(.DECAY_EPOCHS(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .num_samples_i(num_samples), .num_epochs_i(num_epochs),
        .settle_cycles_i(settle_cycles), .lr_init_i(lr_init),
        .sample_idx_o(idx_b), .sample_load_o(load_b), .training_o(train_b),
        .learning_rate_o(lr_b), .epoch_count_o(ep_b), .busy_o(busy_b),
        .done_o(done_b), .aborted_o(abt_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        train_cyc.delete();
        train_idx.delete();
        load_cyc.delete();
        done_cyc.delete();
        abt_cyc.delete();
        busy_cnt = 0;
    endtask

    // one clock edge, then sample 1 time unit later and log DUT A strobes
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (train_a) begin
            train_cyc.push_back(cyc);
            train_idx.push_back(int'(idx_a));
        end
        if (load_a) load_cyc.push_back(cyc);
        if (done_a) done_cyc.push_back(cyc);
        if (abt_a) abt_cyc.push_back(cyc);
        if (busy_a) busy_cnt++;
    endtask

    task automatic start_run(input int n, input int e, input int s, input real lr);
        clear_log();
        num_samples   = (IDX_W + 1)'(n);
        num_epochs    = EP_W'(e);
        settle_cycles = SETTLE_W'(s);
        lr_init       = lr;
        start         = 1'b1;
        step();
        start         = 1'b0;
        t0            = cyc;
    endtask

    task automatic wait_done(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_a) begin
                when = cyc;
                break;
            end
        end
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_train", train_a, 0);
        chk("rst_load", load_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_ep", ep_a, 0);
        chk_r("rst_lr", lr_a, 0.0);
        rst = 1'b1;
        step();

        // 1: N=3 E=2 S=2
        start_run(3, 2, 2, 0.1);
        wait_done(200, at);
        chk("t1_done_at", at - t0, 31);
        chk("t1_first_load", q_at(load_cyc, 0) - t0, 1);
        chk("t1_ntrain", train_cyc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_train_cyc%0d", i), q_at(train_cyc, i) - t0, 4 + 5 * i);
            chk($sformatf("t1_train_idx%0d", i), q_at(train_idx, i), i % 3);
        end
        chk("t1_ep", ep_a, 2);
        chk_r("t1_lr", lr_a, 0.1);
        chk_r("t1_lr_decay", lr_b, 0.05);
        chk("t1_busy_at_done", busy_a, 1);
        step();
        chk("t1_busy_after", busy_a, 0);
        chk("t1_done_after", done_a, 0);
        step();
        chk("t1_ep_hold", ep_a, 2);

        // 2: S=0 N=2 E=1
        start_run(2, 1, 0, 0.2);
        wait_done(100, at);
        chk("t2_done_at", at - t0, 7);
        chk("t2_load0", q_at(load_cyc, 0) - t0, 1);
        chk("t2_train0", q_at(train_cyc, 0) - t0, 2);
        chk("t2_load1", q_at(load_cyc, 1) - t0, 4);
        chk("t2_train1", q_at(train_cyc, 1) - t0, 5);
        chk("t2_ntrain", train_cyc.size(), 2);
        step();

        // 3: N=0, with abort held in FINISH (done wins)
        start_run(0, 4, 2, 0.3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_done_at", done_a, 1);
        chk("t3_aborted", abt_a, 0);
        repeat (3) step();
        chk("t3_busy_cnt", busy_cnt, 1);
        chk("t3_ntrain", train_cyc.size(), 0);
        chk("t3_ndone", done_cyc.size(), 1);
        chk("t3_nabort", abt_cyc.size(), 0);
        chk_r("t3_lr_latched", lr_a, 0.3);
        // 3b: E=0
        start_run(3, 0, 1, 0.3);
        wait_done(20, at);
        chk("t3b_done_at", at - t0, 1);
        repeat (3) step();
        chk("t3b_ntrain", train_cyc.size(), 0);
        chk("t3b_busy_cnt", busy_cnt, 1);

        // 4: decay every 2 epochs (DUT B), N=1 S=0 E=5
        start_run(1, 5, 0, 1.0);
        for (int k = 1; k <= 5; k++) begin
            at = -1;
            for (int i = 0; i < 10; i++) begin
                if (int'(ep_b) == k) begin
                    at = cyc;
                    break;
                end
                step();
            end
            chk($sformatf("t4_ep%0d_at", k), at - t0, 3 * k);
            chk_r($sformatf("t4_lr_ep%0d", k), lr_b, (k >= 4) ? 0.25 : ((k >= 2) ? 0.5 : 1.0));
        end
        wait_done(20, at);
        chk("t4_done_at", at - t0, 16);
        chk_r("t4_lr_b_final", lr_b, 0.25);
        chk_r("t4_lr_a_nodecay", lr_a, 1.0);
        chk("t4_ep_a", ep_a, 5);
        step();

        // 5: abort during SETTLE of sample 1
        start_run(3, 2, 3, 0.5);
        for (int i = 0; i < 30 && load_cyc.size() < 2; i++) step();
        chk("t5_load1_at", q_at(load_cyc, 1) - t0, 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_aborted", abt_a, 1);
        chk("t5_busy_at_abort", busy_a, 1);
        chk("t5_ntrain_at_abort", train_cyc.size(), 1);
        step();
        chk("t5_busy_after", busy_a, 0);
        chk("t5_aborted_after", abt_a, 0);
        repeat (20) step();
        chk("t5_ntrain_later", train_cyc.size(), 1);
        chk("t5_ndone", done_cyc.size(), 0);
        chk("t5_nabort", abt_cyc.size(), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("t5_idle_abort_ignored", abt_cyc.size(), 1);
        start_run(1, 1, 0, 0.5);
        wait_done(20, at);
        chk("t5_restart_done_at", at - t0, 4);
        step();

        // 6: reset while in TRAIN, then start while busy is ignored
        start_run(3, 2, 2, 0.1);
        for (int i = 0; i < 10 && load_cyc.size() < 1; i++) step();
        step();
        step();
        rst = 1'b0;
        step();
        chk("t6_rst_train", train_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_idx", idx_a, 0);
        chk("t6_rst_ep", ep_a, 0);
        chk_r("t6_rst_lr", lr_a, 0.0);
        chk("t6_rst_done", done_a, 0);
        chk("t6_rst_abort", abt_a, 0);
        step();
        rst = 1'b1;
        clear_log();
        repeat (10) step();
        chk("t6_quiet_train", train_cyc.size(), 0);
        chk("t6_quiet_done", done_cyc.size(), 0);
        chk("t6_quiet_abort", abt_cyc.size(), 0);
        chk("t6_quiet_busy", busy_cnt, 0);
        start_run(2, 1, 1, 0.2);
        step();
        step();
        num_samples = (IDX_W + 1)'(5);
        num_epochs  = EP_W'(3);
        start       = 1'b1;
        step();
        start       = 1'b0;
        wait_done(60, at);
        chk("t6_done_at", at - t0, 9);
        chk("t6_ntrain", train_cyc.size(), 2);
        chk("t6_ep", ep_a, 1);
        repeat (5) step();
        chk("t6_no_second_run", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
